// File: rtl/tl_ul_pkg.sv
// Shared TileLink-UL definitions: A/D opcodes, the registered D-channel
// response record and a size/alignment helper.
package tl_ul_pkg;

    localparam logic [2:0] PUT_FULL        = 3'd0;
    localparam logic [2:0] PUT_PARTIAL     = 3'd1;
    localparam logic [2:0] GET             = 3'd4;

    localparam logic [2:0] ACCESS_ACK      = 3'd0;
    localparam logic [2:0] ACCESS_ACK_DATA = 3'd1;

    // Everything the D channel presents except the source, whose width is
    // a parameter of the responder.
    typedef struct packed {
        logic [2:0]  opcode;
        logic [2:0]  size;
        logic        denied;
        logic        corrupt;
        logic [31:0] data;
    } tl_d_rsp_t;

    // Only 1, 2 and 4 byte accesses exist on this 32-bit bus.
    function automatic logic addr_aligned(input logic [2:0] size, input logic [1:0] lsb);
        case (size)
            3'd0:    return 1'b1;
            3'd1:    return ~lsb[0];
            3'd2:    return (lsb == 2'b00);
            default: return 1'b0;
        endcase
    endfunction

endpackage

// File: rtl/tl_ul_sram_bytewe_mem.sv
// DEPTH x 32 storage with per-byte write enables and an asynchronous read
// port sharing the same address. Contents are intentionally never reset.
module tl_ul_sram_bytewe_mem #(
    parameter int DEPTH = 256,
    parameter int AW    = 8
) (
    input  logic          clock,
    input  logic [AW-1:0] addr,
    input  logic [3:0]    byte_we,
    input  logic [31:0]   wdata,
    output logic [31:0]   rdata
);

    logic [31:0] mem [DEPTH];

    always_ff @(posedge clock) begin
        for (int i = 0; i < 4; i++) begin
            if (byte_we[i]) begin
                mem[addr][8*i +: 8] <= wdata[8*i +: 8];
            end
        end
    end

    assign rdata = mem[addr];

endmodule

// File: rtl/tl_ul_sram_responder.sv
// TileLink-UL slave fronting a word-addressed SRAM window. One response
// register gives single-cycle latency and full throughput.
module tl_ul_sram_responder
    import tl_ul_pkg::*;
#(
    parameter logic [30:0] BASE_ADDR = 31'h0000_0000,
    parameter int          DEPTH     = 256,
    parameter int          SOURCE_W  = 3
) (
    input  logic                clock,
    input  logic                reset_n,

    input  logic                a_valid,
    output logic                a_ready,
    input  logic [2:0]          a_opcode,
    input  logic [2:0]          a_param,
    input  logic [2:0]          a_size,
    input  logic [SOURCE_W-1:0] a_source,
    input  logic [30:0]         a_address,
    input  logic [3:0]          a_mask,
    input  logic [31:0]         a_data,
    input  logic                a_corrupt,

    output logic                d_valid,
    input  logic                d_ready,
    output logic [2:0]          d_opcode,
    output logic [1:0]          d_param,
    output logic [2:0]          d_size,
    output logic [SOURCE_W-1:0] d_source,
    output logic                d_sink,
    output logic                d_denied,
    output logic                d_corrupt,
    output logic [31:0]         d_data
);

    localparam int          IDX_W        = $clog2(DEPTH);
    localparam logic [31:0] WINDOW_BYTES = 32'(DEPTH * 4);

    logic                unused_a_param;
    logic                a_fire;
    logic [31:0]         offset;
    logic                hit;
    logic                is_get;
    logic                is_put;
    logic                supported;
    logic                denied;
    logic [IDX_W-1:0]    word_idx;
    logic [3:0]          byte_we;
    logic [31:0]         rdata;
    tl_d_rsp_t           rsp_next;
    tl_d_rsp_t           rsp_q;
    logic [SOURCE_W-1:0] source_q;

    assign unused_a_param = ^a_param;

    assign a_ready = !d_valid || d_ready;
    assign a_fire  = a_valid && a_ready;

    // Addresses below the base wrap to a huge offset, so one compare covers both window edges.
    assign offset   = {1'b0, a_address} - {1'b0, BASE_ADDR};
    assign hit      = (offset < WINDOW_BYTES);
    assign word_idx = offset[2 +: IDX_W];

    assign is_get    = (a_opcode == GET);
    assign is_put    = (a_opcode == PUT_FULL) || (a_opcode == PUT_PARTIAL);
    assign supported = is_get || is_put;
    assign denied    = !hit || !supported || !addr_aligned(a_size, a_address[1:0]);

    assign byte_we = (a_fire && is_put && !denied && !a_corrupt) ? a_mask : 4'b0000;

    tl_ul_sram_bytewe_mem #(
        .DEPTH (DEPTH),
        .AW    (IDX_W)
    ) u_mem (
        .clock   (clock),
        .addr    (word_idx),
        .byte_we (byte_we),
        .wdata   (a_data),
        .rdata   (rdata)
    );

    always_comb begin
        rsp_next        = '0;
        rsp_next.size   = a_size;
        rsp_next.denied = denied;
        if (is_get) begin
            rsp_next.opcode  = ACCESS_ACK_DATA;
            rsp_next.corrupt = denied;
            rsp_next.data    = denied ? 32'h0 : rdata;
        end else begin
            rsp_next.opcode  = ACCESS_ACK;
        end
    end

    // A new beat always overwrites the register; a lone D fire just drops valid.
    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            d_valid  <= 1'b0;
            rsp_q    <= '0;
            source_q <= '0;
        end else if (a_fire) begin
            d_valid  <= 1'b1;
            rsp_q    <= rsp_next;
            source_q <= a_source;
        end else if (d_ready) begin
            d_valid  <= 1'b0;
        end
    end

    assign d_opcode  = rsp_q.opcode;
    assign d_param   = 2'b00;
    assign d_size    = rsp_q.size;
    assign d_source  = source_q;
    assign d_sink    = 1'b0;
    assign d_denied  = rsp_q.denied;
    assign d_corrupt = rsp_q.corrupt;
    assign d_data    = rsp_q.data;

endmodule
